control_pipe: RTL and testbench

CONTROL_PIPE -- requirements
Module: control_pipe

---
 rtl/control_pipe.sv | 163 ++++++++++++++++
 tb/tb_control_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// Control pipe: decodes the ID instruction and carries its control bits through EX, MEM and WB.
// Load-use hazard detection is compiled in only when CONTROL_PIPE_LOAD_USE_STALL_EN is defined.
module control_pipe #(
    parameter int RD_W  = 5,
    parameter bit RV32E = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_in,
    input  logic            id_valid,
    input  logic            flush_in,
    input  logic            stall_ext,
    output logic            id_stall,
    output logic            illegal_out,
    output logic            ex_valid,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_jalr,
    output logic [1:0]      ex_ula_op,
    output logic [1:0]      ex_alu_src1,
    output logic [1:0]      ex_alu_src2,
    output logic            mem_valid,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            wb_valid,
    output logic            wb_reg_wr,
    output logic            wb_mux_reg_wr,
    output logic [RD_W-1:0] wb_rd
);

    typedef struct packed {
        logic            valid;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [1:0]      ula_op;
        logic [1:0]      src1;
        logic [1:0]      src2;
        logic            mem_rd;
        logic            mem_wr;
        logic            reg_wr;
        logic            mux;
        logic [RD_W-1:0] rd;
    } ex_t;

    typedef struct packed {
        logic            valid;
        logic            mem_rd;
        logic            mem_wr;
        logic            reg_wr;
        logic            mux;
        logic [RD_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic            valid;
        logic            reg_wr;
        logic            mux;
        logic [RD_W-1:0] rd;
    } wb_t;

    ex_t  ex_d,  ex_q;
    mem_t mem_d, mem_q;
    wb_t  wb_d,  wb_q;

    ex_t  dec;
    logic known, uses_rs1, uses_rs2, writes_rd, rv32e_bad;

    logic [6:0]      opcode;
    logic [RD_W-1:0] rd_f;
    logic            unused_instr;

    assign opcode       = instr_in[6:0];
    assign rd_f         = instr_in[7 +: RD_W];
    assign unused_instr = ^instr_in[31:12];

    always_comb begin
        dec       = '0;
        known     = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        writes_rd = 1'b1;
        case (opcode)
            7'b0110011: begin dec.ula_op = 2'b10; uses_rs2 = 1'b1; end
            7'b0010011: begin dec.ula_op = 2'b10; dec.src2 = 2'b01; end
            7'b0000011: begin dec.src2 = 2'b01; dec.mem_rd = 1'b1; dec.mux = 1'b1; end
            7'b0100011: begin dec.src2 = 2'b01; dec.mem_wr = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b0; end
            7'b1100011: begin dec.ula_op = 2'b01; dec.branch = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b0; end
            7'b0110111: begin dec.src1 = 2'b10; dec.src2 = 2'b01; uses_rs1 = 1'b0; end
            7'b0010111: begin dec.src1 = 2'b01; dec.src2 = 2'b01; uses_rs1 = 1'b0; end
            7'b1101111: begin dec.src1 = 2'b01; dec.src2 = 2'b10; dec.jump = 1'b1; uses_rs1 = 1'b0; end
            7'b1100111: begin dec.src1 = 2'b01; dec.src2 = 2'b10; dec.jump = 1'b1; dec.jalr = 1'b1; end
            default:    begin known = 1'b0; uses_rs1 = 1'b0; writes_rd = 1'b0; end
        endcase
        dec.valid  = 1'b1;
        // wb_rd only carries a real destination; x0 never gets a write enable
        dec.rd     = writes_rd ? rd_f : '0;
        dec.reg_wr = writes_rd && (rd_f != '0);
    end

    // RV32E has 16 registers, so bit 4 of any used register field is out of range
    assign rv32e_bad   = RV32E && ((writes_rd && instr_in[11]) ||
                                   (uses_rs1 && instr_in[19]) ||
                                   (uses_rs2 && instr_in[24]));
    assign illegal_out = id_valid && (!known || rv32e_bad);

`ifdef CONTROL_PIPE_LOAD_USE_STALL_EN
    logic [RD_W-1:0] rs1_f, rs2_f;
    assign rs1_f    = instr_in[15 +: RD_W];
    assign rs2_f    = instr_in[20 +: RD_W];
    assign id_stall = id_valid && ex_q.valid && ex_q.mem_rd && (ex_q.rd != '0) &&
                      ((uses_rs1 && (rs1_f == ex_q.rd)) || (uses_rs2 && (rs2_f == ex_q.rd)));
`else
    assign id_stall = 1'b0;
`endif

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!stall_ext) begin
            ex_d         = (flush_in || id_stall || !id_valid || illegal_out) ? '0 : dec;
            mem_d.valid  = ex_q.valid;
            mem_d.mem_rd = ex_q.mem_rd;
            mem_d.mem_wr = ex_q.mem_wr;
            mem_d.reg_wr = ex_q.reg_wr;
            mem_d.mux    = ex_q.mux;
            mem_d.rd     = ex_q.rd;
            wb_d.valid   = mem_q.valid;
            wb_d.reg_wr  = mem_q.reg_wr;
            wb_d.mux     = mem_q.mux;
            wb_d.rd      = mem_q.rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
    assign ex_jalr       = ex_q.jalr;
    assign ex_ula_op     = ex_q.ula_op;
    assign ex_alu_src1   = ex_q.src1;
    assign ex_alu_src2   = ex_q.src2;
    assign mem_valid     = mem_q.valid;
    assign mem_rd        = mem_q.mem_rd;
    assign mem_wr        = mem_q.mem_wr;
    assign wb_valid      = wb_q.valid;
    assign wb_reg_wr     = wb_q.reg_wr;
    assign wb_mux_reg_wr = wb_q.mux;
    assign wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: decode table with a latency scoreboard, plus stall, load-use and reset sequences.
module tb_control_pipe;

    logic        clk = 1'b0;
    logic        rst, id_valid, flush_in, stall_ext;
    logic [31:0] instr_in;
    logic        id_stall, illegal_out, ex_valid, ex_branch, ex_jump, ex_jalr;
    logic [1:0]  ex_ula_op, ex_alu_src1, ex_alu_src2;
    logic        mem_valid, mem_rd, mem_wr, wb_valid, wb_reg_wr, wb_mux_reg_wr;
    logic [4:0]  wb_rd;

    logic        e_id_stall, e_illegal, e_ex_valid, e_ex_branch, e_ex_jump, e_ex_jalr;
    logic [1:0]  e_ula, e_s1, e_s2;
    logic        e_mem_valid, e_mem_rd, e_mem_wr, e_wb_valid, e_wb_reg_wr, e_wb_mux;
    logic [4:0]  e_wb_rd;

    always #5 clk = ~clk;

    control_pipe #(.RD_W(5), .RV32E(1'b0)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .id_valid(id_valid),
        .flush_in(flush_in), .stall_ext(stall_ext), .id_stall(id_stall),
        .illegal_out(illegal_out), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_ula_op(ex_ula_op),
        .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2), .mem_valid(mem_valid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr),
        .wb_mux_reg_wr(wb_mux_reg_wr), .wb_rd(wb_rd)
    );

    control_pipe #(.RD_W(5), .RV32E(1'b1)) dut_e (
        .clk(clk), .rst(rst), .instr_in(instr_in), .id_valid(id_valid),
        .flush_in(flush_in), .stall_ext(stall_ext), .id_stall(e_id_stall),
        .illegal_out(e_illegal), .ex_valid(e_ex_valid), .ex_branch(e_ex_branch),
        .ex_jump(e_ex_jump), .ex_jalr(e_ex_jalr), .ex_ula_op(e_ula),
        .ex_alu_src1(e_s1), .ex_alu_src2(e_s2), .mem_valid(e_mem_valid),
        .mem_rd(e_mem_rd), .mem_wr(e_mem_wr), .wb_valid(e_wb_valid), .wb_reg_wr(e_wb_reg_wr),
        .wb_mux_reg_wr(e_wb_mux), .wb_rd(e_wb_rd)
    );

    typedef struct {
        logic [31:0] instr;
        logic        v;
        logic        fl;
        logic        ill;
        logic [9:0]  ex;   // {valid,branch,jump,jalr,ula_op,src1,src2}
        logic [2:0]  mem;  // {valid,mem_rd,mem_wr}
        logic [7:0]  wb;   // {valid,reg_wr,mux,rd}
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tbl[17];
    vec_t exp_q[$];
    logic stall_exp;

    function automatic vec_t mk(input logic [31:0] instr, input logic v, input logic fl,
                                input logic ill, input logic val, input logic br, input logic j,
                                input logic jr, input logic [1:0] ula, input logic [1:0] s1,
                                input logic [1:0] s2, input logic mr, input logic mw,
                                input logic rw, input logic mux, input logic [4:0] rd);
        vec_t r;
        r.instr = instr; r.v = v; r.fl = fl; r.ill = ill;
        r.ex  = {val, br, j, jr, ula, s1, s2};
        r.mem = {val, mr, mw};
        r.wb  = {val, rw, mux, rd};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] ex_vec();
        return {ex_valid, ex_branch, ex_jump, ex_jalr, ex_ula_op, ex_alu_src1, ex_alu_src2};
    endfunction

    function automatic logic [20:0] all_out();
        return {ex_vec(), mem_valid, mem_rd, mem_wr, wb_valid, wb_reg_wr, wb_mux_reg_wr, wb_rd};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic v, input logic fl);
        @(negedge clk);
        instr_in = instr; id_valid = v; flush_in = fl;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef CONTROL_PIPE_LOAD_USE_STALL_EN
        stall_exp = 1'b1;
`else
        stall_exp = 1'b0;
`endif
        //            instr         v  fl ill val br j jr ula    s1     s2     mr mw rw mux rd
        tbl[0]  = mk(32'h002081B3, 1, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 5'd3);
        tbl[1]  = mk(32'h00500213, 1, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b01, 0, 0, 1, 0, 5'd4);
        tbl[2]  = mk(32'h0000A283, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0, 1, 1, 5'd5);
        tbl[3]  = mk(32'h0020A223, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 0, 5'd0);
        tbl[4]  = mk(32'h00208063, 1, 0, 0, 1, 1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        tbl[5]  = mk(32'h123453B7, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 0, 1, 0, 5'd7);
        tbl[6]  = mk(32'h00001417, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 0, 1, 0, 5'd8);
        tbl[7]  = mk(32'h000000EF, 1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b01, 2'b10, 0, 0, 1, 0, 5'd1);
        tbl[8]  = mk(32'h00008067, 1, 0, 0, 1, 0, 1, 1, 2'b00, 2'b01, 2'b10, 0, 0, 0, 0, 5'd0);
        tbl[9]  = mk(32'h00000013, 1, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b01, 0, 0, 0, 0, 5'd0);
        tbl[10] = mk(32'h0000007F, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        tbl[11] = mk(32'h002081B3, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        tbl[12] = mk(32'h002084B3, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        tbl[13] = mk(32'h002081B3, 1, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 5'd3);
        for (int i = 14; i < 17; i++)
            tbl[i] = mk(32'h0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);

        rst = 1'b1; instr_in = 32'h002081B3; id_valid = 1'b1; flush_in = 1'b0; stall_ext = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", {11'd0, all_out()}, 32'd0);
        @(negedge clk) rst = 1'b0;

        // decode table through the scoreboard: EX at +1, MEM at +2, WB at +3
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].instr, tbl[i].v, tbl[i].fl);
            exp_q.push_back(tbl[i]);
            #1;
            chk($sformatf("illegal[%0d]", i), {31'd0, illegal_out}, {31'd0, tbl[i].ill});
            chk($sformatf("id_stall[%0d]", i), {31'd0, id_stall}, 32'd0);
            edge_wait();
            chk($sformatf("ex[%0d]", i), {22'd0, ex_vec()}, {22'd0, exp_q[$].ex});
            if (exp_q.size() >= 2)
                chk($sformatf("mem[%0d]", i), {29'd0, mem_valid, mem_rd, mem_wr},
                    {29'd0, exp_q[$-1].mem});
            if (exp_q.size() >= 3)
                chk($sformatf("wb[%0d]", i), {24'd0, wb_valid, wb_reg_wr, wb_mux_reg_wr, wb_rd},
                    {24'd0, exp_q[$-2].wb});
            if (exp_q.size() > 3) void'(exp_q.pop_front());
        end
        exp_q.delete();

        // external stall with lw in MEM: everything freezes, then resumes in order
        begin
            logic [7:0] wb_snap;
            drive(32'h0000A283, 1, 0); edge_wait();
            drive(32'h00500213, 1, 0); edge_wait();
            wb_snap = {wb_valid, wb_reg_wr, wb_mux_reg_wr, wb_rd};
            for (int k = 0; k < 3; k++) begin
                drive(32'h002081B3, 1, 0);
                stall_ext = 1'b1;
                edge_wait();
                chk($sformatf("stall_mem[%0d]", k), {29'd0, mem_valid, mem_rd, mem_wr}, 32'd6);
                chk($sformatf("stall_ex[%0d]", k), {22'd0, ex_vec()}, {22'd0, 10'b1000100001});
                chk($sformatf("stall_wb[%0d]", k),
                    {24'd0, wb_valid, wb_reg_wr, wb_mux_reg_wr, wb_rd}, {24'd0, wb_snap});
            end
            drive(32'h0, 0, 0);
            stall_ext = 1'b0;
            edge_wait();
            chk("resume_wb_lw", {24'd0, wb_valid, wb_reg_wr, wb_mux_reg_wr, wb_rd}, {24'd0, 8'b11100101});
            chk("resume_mem_addi", {29'd0, mem_valid, mem_rd, mem_wr}, 32'd4);
            edge_wait();
            chk("resume_wb_addi", {24'd0, wb_valid, wb_reg_wr, wb_mux_reg_wr, wb_rd}, {24'd0, 8'b11000100});
        end

        // load-use: lw x5 then add x6,x5,x1
        begin
            int  e;
            logic found;
            drive(32'h0000A283, 1, 0); edge_wait(); e = 1;
            drive(32'h00128333, 1, 0);
            #1 chk("lu_stall", {31'd0, id_stall}, {31'd0, stall_exp});
            edge_wait(); e++;
            if (stall_exp) begin
                chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
                drive(32'h00128333, 1, 0);
                #1 chk("lu_stall_clear", {31'd0, id_stall}, 32'd0);
                edge_wait(); e++;
            end
            chk("lu_ex_add", {22'd0, ex_vec()}, {22'd0, 10'b1000100000});
            drive(32'h0, 0, 0);
            found = 1'b0;
            for (int k = 0; k < 8 && !found; k++) begin
                edge_wait(); e++;
                if (wb_valid && wb_rd == 5'd6) found = 1'b1;
            end
            chk("lu_wb_found", {31'd0, found}, 32'd1);
            chk("lu_wb_cycle", e, stall_exp ? 32'd5 : 32'd4);
            chk("lu_wb_regwr", {30'd0, wb_reg_wr, wb_mux_reg_wr}, 32'd2);
        end

        // reset while jal sits in MEM, combined with an external stall
        drive(32'h000000EF, 1, 0); edge_wait();
        drive(32'h0, 0, 0); edge_wait();
        chk("jal_in_mem", {29'd0, mem_valid, mem_rd, mem_wr}, 32'd4);
        drive(32'h002081B3, 1, 1);
        rst = 1'b1; stall_ext = 1'b1;
        edge_wait();
        chk("rst_all_zero", {11'd0, all_out()}, 32'd0);
        drive(32'h0, 0, 0);
        rst = 1'b0; stall_ext = 1'b0;
        edge_wait();
        chk("rst_no_wb_pulse", {11'd0, all_out()}, 32'd0);

        // RV32E register range
        drive(32'h002088B3, 1, 0);
        #1;
        chk("rv32e_x17_illegal", {31'd0, e_illegal}, 32'd1);
        chk("rv32i_x17_legal", {31'd0, illegal_out}, 32'd0);
        drive(32'h002081B3, 1, 0);
        #1 chk("rv32e_x3_legal", {31'd0, e_illegal}, 32'd0);
        drive(32'h0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
